// File: rtl/tl45_rf_write_arbiter_pkg.sv
// Shared types for the TL45 register-file write arbiter: write-entry struct,
// arbiter state encoding and the "no destination" register number.
package tl45_pkg;

  localparam logic [3:0] REG_ZERO = 4'd0;

  typedef struct packed {
    logic [3:0]  dr;
    logic [31:0] val;
  } rf_wr_t;

  typedef enum logic {
    ARB_NORMAL,
    ARB_HOLD
  } arb_state_t;

endpackage

// File: rtl/tl45_rf_write_arbiter_if.sv
// Bundle of writeback, LLU, forwarding and register-file write signals
// shared by the arbiter and whoever drives/observes it.
interface tl45_rf_write_arbiter_if;

  logic [3:0]  i_wb_dr;
  logic [31:0] i_wb_val;
  logic        i_ll_valid;
  logic [3:0]  i_ll_dr;
  logic [31:0] i_ll_val;
  logic        o_ll_ready;
  logic        o_pipe_stall;
  logic [3:0]  o_fwd_reg;
  logic [31:0] o_fwd_val;
  logic        o_rf_en;
  logic [3:0]  o_rf_reg;
  logic [31:0] o_rf_val;

  modport master (
    output i_wb_dr, i_wb_val, i_ll_valid, i_ll_dr, i_ll_val,
    input  o_ll_ready, o_pipe_stall, o_fwd_reg, o_fwd_val,
    input  o_rf_en, o_rf_reg, o_rf_val
  );

  modport slave (
    input  i_wb_dr, i_wb_val, i_ll_valid, i_ll_dr, i_ll_val,
    output o_ll_ready, o_pipe_stall, o_fwd_reg, o_fwd_val,
    output o_rf_en, o_rf_reg, o_rf_val
  );

endinterface

// File: rtl/tl45_rf_write_arbiter.sv
// Arbitrates the single register-file write port between writeback (priority)
// and the long-latency unit, forcing the LLU through after STARVE_LIMIT losses.
module tl45_rf_write_arbiter
  import tl45_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input logic                   i_clk,
  input logic                   i_reset_n,
  tl45_rf_write_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  rf_wr_t           hold;
  rf_wr_t           rf_q;
  logic             rf_en_q;
  logic             stall_q;

  rf_wr_t wb_entry;
  rf_wr_t ll_entry;
  rf_wr_t grant;
  logic   grant_valid;
  logic   ll_ready;
  logic   wb_req;
  logic   ll_req;
  logic   at_limit;
  logic   force_ll;

  assign wb_req   = (bus.i_wb_dr != REG_ZERO);
  assign ll_req   = bus.i_ll_valid;
  assign at_limit = (starve_cnt >= LIMIT);
  assign force_ll = (state == ARB_NORMAL) && wb_req && ll_req && at_limit;
  assign wb_entry = {bus.i_wb_dr, bus.i_wb_val};
  assign ll_entry = {bus.i_ll_dr, bus.i_ll_val};

  // Exactly one winner per cycle; in HOLD the parked writeback entry owns the port.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    ll_ready    = 1'b0;
    if (state == ARB_HOLD) begin
      grant       = hold;
      grant_valid = 1'b1;
    end else if (wb_req && !(ll_req && at_limit)) begin
      grant       = wb_entry;
      grant_valid = 1'b1;
    end else if (ll_req) begin
      grant       = ll_entry;
      grant_valid = 1'b1;
      ll_ready    = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ARB_NORMAL;
      starve_cnt <= '0;
      hold       <= '0;
      stall_q    <= 1'b0;
      rf_en_q    <= 1'b0;
      rf_q       <= '0;
    end else begin
      rf_en_q <= grant_valid;
      if (grant_valid) begin
        rf_q <= grant;
      end
      case (state)
        ARB_NORMAL: begin
          if (force_ll) begin
            hold       <= wb_entry;
            starve_cnt <= '0;
            stall_q    <= 1'b1;
            state      <= ARB_HOLD;
          end else if (wb_req && ll_req) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end else begin
            starve_cnt <= '0;
          end
        end
        ARB_HOLD: begin
          stall_q <= 1'b0;
          state   <= ARB_NORMAL;
        end
      endcase
    end
  end

  // LLU results are never forwarded; the held entry is what the pipeline sees during HOLD.
  assign bus.o_fwd_reg    = (state == ARB_HOLD) ? hold.dr  : bus.i_wb_dr;
  assign bus.o_fwd_val    = (state == ARB_HOLD) ? hold.val : bus.i_wb_val;
  assign bus.o_ll_ready   = ll_ready;
  assign bus.o_pipe_stall = stall_q;
  assign bus.o_rf_en      = rf_en_q;
  assign bus.o_rf_reg     = rf_q.dr;
  assign bus.o_rf_val     = rf_q.val;

endmodule

// File: tb/tb_tl45_rf_write_arbiter.sv
// Directed bench for tl45_rf_write_arbiter; register-file writes are matched
// in order against a queue of expected entries.
module tb_tl45_rf_write_arbiter;
  import tl45_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   check_count = 0;
  int   pass_count  = 0;
  int   fail_count  = 0;
  rf_wr_t exp_q[$];

  tl45_rf_write_arbiter_if bus();

  tl45_rf_write_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic rf_wr_t mk(input logic [3:0] dr, input logic [31:0] val);
    rf_wr_t w;
    w.dr  = dr;
    w.val = val;
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] wb_dr, input logic [31:0] wb_val,
                               input logic ll_valid, input logic [3:0] ll_dr, input logic [31:0] ll_val);
    @(posedge clk);
    #1;
    bus.i_wb_dr    = wb_dr;
    bus.i_wb_val   = wb_val;
    bus.i_ll_valid = ll_valid;
    bus.i_ll_dr    = ll_dr;
    bus.i_ll_val   = ll_val;
  endtask

  // Four writeback wins against a pending LLU, then the forced LLU slot.
  task automatic forceSequence(input logic [3:0] ll_dr, input logic [31:0] ll_val,
                               input logic [3:0] f_dr, input logic [31:0] f_val);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(4'(i), 32'h1000 + 32'(i), 1'b1, ll_dr, ll_val);
      exp_q.push_back(mk(4'(i), 32'h1000 + 32'(i)));
      @(negedge clk);
      checkOutput("ll_ready_lost", 32'(bus.o_ll_ready), 32'd0);
      checkOutput("stall_normal", 32'(bus.o_pipe_stall), 32'd0);
    end
    applyStimulus(f_dr, f_val, 1'b1, ll_dr, ll_val);
    exp_q.push_back(mk(ll_dr, ll_val));
    @(negedge clk);
    checkOutput("ll_ready_forced", 32'(bus.o_ll_ready), 32'd1);
    checkOutput("fwd_reg_forced", 32'(bus.o_fwd_reg), 32'(f_dr));
  endtask

  // Scoreboard: every observed register-file write must match the oldest expected entry.
  always @(negedge clk) begin
    rf_wr_t want;
    if (rst_n && bus.o_rf_en) begin
      check_count++;
      assert (exp_q.size() != 0) pass_count++;
      else begin
        fail_count++;
        $error("[TB] FAIL rf_unexpected_write observed=r%0d/0x%0h expected=no write",
               bus.o_rf_reg, bus.o_rf_val);
      end
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        checkOutput("rf_reg", 32'(bus.o_rf_reg), 32'(want.dr));
        checkOutput("rf_val", bus.o_rf_val, want.val);
      end
    end
  end

  initial begin
    bus.i_wb_dr    = 4'd2;
    bus.i_wb_val   = 32'h22;
    bus.i_ll_valid = 1'b0;
    bus.i_ll_dr    = 4'd0;
    bus.i_ll_val   = 32'd0;

    @(negedge clk);
    checkOutput("reset_rf_en", 32'(bus.o_rf_en), 32'd0);
    checkOutput("reset_stall", 32'(bus.o_pipe_stall), 32'd0);
    checkOutput("reset_rf_reg", 32'(bus.o_rf_reg), 32'd0);
    checkOutput("reset_rf_val", bus.o_rf_val, 32'd0);
    checkOutput("reset_fwd_reg", 32'(bus.o_fwd_reg), 32'd2);
    checkOutput("reset_fwd_val", bus.o_fwd_val, 32'h22);
    bus.i_wb_dr  = 4'd0;
    bus.i_wb_val = 32'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] writeback only");
    applyStimulus(4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
    exp_q.push_back(mk(4'd3, 32'hDEADBEEF));
    @(negedge clk);
    checkOutput("wb_fwd_reg", 32'(bus.o_fwd_reg), 32'd3);
    checkOutput("wb_fwd_val", bus.o_fwd_val, 32'hDEADBEEF);
    checkOutput("wb_ll_ready", 32'(bus.o_ll_ready), 32'd0);
    applyStimulus(4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

    $display("[TB] LLU only");
    applyStimulus(4'd0, 32'd0, 1'b1, 4'd5, 32'h12);
    exp_q.push_back(mk(4'd5, 32'h12));
    @(negedge clk);
    checkOutput("llu_ready", 32'(bus.o_ll_ready), 32'd1);
    checkOutput("llu_fwd_reg", 32'(bus.o_fwd_reg), 32'd0);
    applyStimulus(4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    applyStimulus(4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("idle_rf_en", 32'(bus.o_rf_en), 32'd0);
    checkOutput("idle_rf_reg_held", 32'(bus.o_rf_reg), 32'd5);
    checkOutput("idle_rf_val_held", bus.o_rf_val, 32'h12);

    $display("[TB] starvation");
    forceSequence(4'd9, 32'h900, 4'd5, 32'h1005);
    applyStimulus(4'd6, 32'h1006, 1'b0, 4'd0, 32'd0);
    exp_q.push_back(mk(4'd5, 32'h1005));
    @(negedge clk);
    checkOutput("hold_stall", 32'(bus.o_pipe_stall), 32'd1);
    checkOutput("hold_fwd_reg", 32'(bus.o_fwd_reg), 32'd5);
    checkOutput("hold_fwd_val", bus.o_fwd_val, 32'h1005);
    checkOutput("hold_ll_ready", 32'(bus.o_ll_ready), 32'd0);
    applyStimulus(4'd6, 32'h1006, 1'b0, 4'd0, 32'd0);
    exp_q.push_back(mk(4'd6, 32'h1006));
    @(negedge clk);
    checkOutput("post_hold_stall", 32'(bus.o_pipe_stall), 32'd0);
    checkOutput("post_hold_fwd_reg", 32'(bus.o_fwd_reg), 32'd6);
    applyStimulus(4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    applyStimulus(4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

    $display("[TB] same-destination collision");
    forceSequence(4'd7, 32'hB, 4'd7, 32'hA);
    applyStimulus(4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    exp_q.push_back(mk(4'd7, 32'hA));
    @(negedge clk);
    checkOutput("coll_fwd_reg", 32'(bus.o_fwd_reg), 32'd7);
    checkOutput("coll_fwd_val", bus.o_fwd_val, 32'hA);
    applyStimulus(4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    applyStimulus(4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

    $display("[TB] LLU withdraw clears starvation");
    for (int i = 1; i <= 2; i++) begin
      applyStimulus(4'(i), 32'h2000 + 32'(i), 1'b1, 4'd9, 32'h909);
      exp_q.push_back(mk(4'(i), 32'h2000 + 32'(i)));
      @(negedge clk);
      checkOutput("withdraw_ll_ready", 32'(bus.o_ll_ready), 32'd0);
    end
    applyStimulus(4'd3, 32'h2003, 1'b0, 4'd0, 32'd0);
    exp_q.push_back(mk(4'd3, 32'h2003));
    forceSequence(4'd9, 32'h909, 4'd8, 32'h1008);
    applyStimulus(4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    exp_q.push_back(mk(4'd8, 32'h1008));
    applyStimulus(4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    applyStimulus(4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

    $display("[TB] reset during HOLD");
    forceSequence(4'd9, 32'h999, 4'd5, 32'h5555);
    applyStimulus(4'd6, 32'h666, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("rst_hold_stall", 32'(bus.o_pipe_stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_hold_rf_en", 32'(bus.o_rf_en), 32'd0);
    checkOutput("rst_hold_stall_clr", 32'(bus.o_pipe_stall), 32'd0);
    checkOutput("rst_hold_fwd_reg", 32'(bus.o_fwd_reg), 32'd6);
    checkOutput("rst_hold_fwd_val", bus.o_fwd_val, 32'h666);
    applyStimulus(4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    applyStimulus(4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("after_rst_rf_en", 32'(bus.o_rf_en), 32'd0);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
